// File: rtl/hdmi_pixel_out.sv
// -----------------------------------------------------------------------------
// hdmi_pixel_out
//
// Output stage after the YUV->RGB converter. RGB pixel pairs are written into
// a small FIFO, then unpacked into one 24-bit pixel per clock under locally
// generated DVI/HDMI raster timing (hsync, vsync, data enable).
//
// Ports
//   clk24       in   pixel clock, one pixel per cycle
//   rst         in   synchronous, active-high reset
//   pair_in     in   {red1,blue1,green1,red0,blue0,green0}; pixel 0 = [23:0]
//   pair_sof    in   marks pair_in as the first pair of a frame
//   pair_we     in   write strobe
//   pair_ready  out  FIFO not full (combinational from the registered level)
//   vid_data    out  {red,green,blue}
//   vid_de      out  active video
//   vid_hsync   out  horizontal sync, driven at SYNC_POL while asserted
//   vid_vsync   out  vertical sync, driven at SYNC_POL while asserted
//   underflow   out  sticky: an even active slot in RUN found the FIFO empty
//   overflow    out  sticky: pair_we seen while the FIFO was full
//   fifo_level  out  current FIFO occupancy
//
// Build option
//   HDMI_OUT_TEST_PATTERN_EN  when defined, pixels that would otherwise be
//   black (waiting for SOF, or after an underflow) show eight vertical colour
//   bars. Timing, FIFO and flag behaviour do not change.
// -----------------------------------------------------------------------------
module hdmi_pixel_out #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int FIFO_DEPTH = 16,
  parameter bit SYNC_POL   = 1'b0
) (
  input  logic                          clk24,
  input  logic                          rst,
  input  logic [47:0]                   pair_in,
  input  logic                          pair_sof,
  input  logic                          pair_we,
  output logic                          pair_ready,
  output logic [23:0]                   vid_data,
  output logic                          vid_de,
  output logic                          vid_hsync,
  output logic                          vid_vsync,
  output logic                          underflow,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // One spare code so that every boundary constant up to the total fits.
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_LAST_C = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HS_BEG_C = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END_C = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_LAST_C = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VS_BEG_C = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END_C = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [LW-1:0] FULL_C   = LW'(FIFO_DEPTH);

  typedef enum logic {WAIT_SOF, RUN} state_e;

  // Stored pixel half is {r,b,g}; the link wants {r,g,b}.
  function automatic logic [23:0] rbg_to_rgb(input logic [23:0] x);
    return {x[23:16], x[7:0], x[15:8]};
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [HW-1:0] h_cnt_q;
  logic [VW-1:0] v_cnt_q;
  state_e        state_q, state_d;
  logic [23:0]   hi_q, hi_d;           // pixel 1 of the pair popped on the even slot
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          underflow_q, underflow_d;
  logic          overflow_q;
  logic [23:0]   vid_data_q;
  logic          vid_de_q, vid_hsync_q, vid_vsync_q;
  logic [48:0]   mem_q [FIFO_DEPTH];   // {sof, pair}

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic        active, empty, push, pop, run_now, at_origin;
  logic        hs_on, vs_on;
  logic [48:0] head;
  logic [23:0] fill_pix, pix;

  assign pair_ready = (level_q != FULL_C);
  assign push       = pair_we && pair_ready;
  assign empty      = (level_q == '0);
  assign head       = mem_q[rd_ptr_q];
  assign active     = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
  assign at_origin  = (h_cnt_q == '0) && (v_cnt_q == '0);
  assign hs_on      = (h_cnt_q >= HS_BEG_C) && (h_cnt_q < HS_END_C);
  assign vs_on      = (v_cnt_q >= VS_BEG_C) && (v_cnt_q < VS_END_C);

`ifdef HDMI_OUT_TEST_PATTERN_EN
  localparam logic [HW-1:0] BAR_W_C = HW'(H_ACTIVE / 8);
  logic [HW-1:0] bar_idx;
  assign bar_idx = h_cnt_q / BAR_W_C;

  always_comb begin
    case (bar_idx)
      HW'(0):  fill_pix = 24'hFFFFFF;  // white
      HW'(1):  fill_pix = 24'hFFFF00;  // yellow
      HW'(2):  fill_pix = 24'h00FFFF;  // cyan
      HW'(3):  fill_pix = 24'h00FF00;  // green
      HW'(4):  fill_pix = 24'hFF00FF;  // magenta
      HW'(5):  fill_pix = 24'hFF0000;  // red
      HW'(6):  fill_pix = 24'h0000FF;  // blue
      default: fill_pix = 24'h000000;  // black
    endcase
  end
`else
  assign fill_pix = 24'h000000;
`endif

  // NOTE: every signal written here gets a default before any branch, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    underflow_d = underflow_q;
    pop         = 1'b0;
    pix         = 24'h000000;
    run_now     = (state_q == RUN);

    if (state_q == WAIT_SOF && !empty) begin
      if (!head[48]) begin
        pop = 1'b1;                    // stale mid-frame data: drop one per cycle
      end else if (at_origin) begin
        state_d = RUN;                 // SOF at the frame origin: start this very slot
        run_now = 1'b1;
      end
    end

    if (active) begin
      pix = fill_pix;
      if (run_now) begin
        if (!h_cnt_q[0]) begin
          if (empty) begin
            underflow_d = 1'b1;
            state_d     = WAIT_SOF;
          end else begin
            pop  = 1'b1;
            pix  = rbg_to_rgb(head[23:0]);
            hi_d = head[47:24];
          end
        end else begin
          pix = rbg_to_rgb(hi_q);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk24) begin
    if (rst) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      state_q     <= WAIT_SOF;
      hi_q        <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
      vid_data_q  <= '0;
      vid_de_q    <= 1'b0;
      vid_hsync_q <= ~SYNC_POL;
      vid_vsync_q <= ~SYNC_POL;
    end else begin
      if (h_cnt_q == H_LAST_C) begin
        h_cnt_q <= '0;
        v_cnt_q <= (v_cnt_q == V_LAST_C) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_q <= h_cnt_q + 1'b1;
      end

      state_q     <= state_d;
      hi_q        <= hi_d;
      underflow_q <= underflow_d;
      overflow_q  <= overflow_q | (pair_we && !pair_ready);

      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase

      vid_data_q  <= pix;
      vid_de_q    <= active;
      vid_hsync_q <= hs_on ? SYNC_POL : ~SYNC_POL;
      vid_vsync_q <= vs_on ? SYNC_POL : ~SYNC_POL;
    end
  end

  // NOTE: the storage array has no reset; clearing the pointers and level
  // empties the FIFO, and stale words are never read before being rewritten.
  always_ff @(posedge clk24) begin
    if (push) mem_q[wr_ptr_q] <= {pair_sof, pair_in};
  end

  assign vid_data   = vid_data_q;
  assign vid_de     = vid_de_q;
  assign vid_hsync  = vid_hsync_q;
  assign vid_vsync  = vid_vsync_q;
  assign underflow  = underflow_q;
  assign overflow   = overflow_q;
  assign fifo_level = level_q;

endmodule

// File: doc/hdmi_pixel_out.md
# hdmi_pixel_out

Downstream stage of the YUV→RGB conversion core. It accepts 48-bit RGB pixel pairs in the core's packing, buffers them in a small FIFO and unpacks each pair into two 24-bit pixels. It also generates 640x480 HDMI/DVI video timing (hsync, vsync, data-enable) and presents one pixel per active slot. It sits between the converter/frame buffer and the HDMI transmitter PHY.

## Interface
Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in clocks
- V_ACTIVE, 480, active lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines
- FIFO_DEPTH, 16, pair entries; power of two, at least 4
- SYNC_POL, 0, sync active level (0 = active-low)

Ports:
- clk24  in  1  pixel clock; one pixel per cycle
- rst  in  1  synchronous, active-high reset
- pair_in  in  48  {red1,blue1,green1,red0,blue0,green0}; pixel 0 is bits [23:0]
- pair_sof  in  1  qualifies pair_in as the first pair of a frame
- pair_we  in  1  write strobe
- pair_ready  out  1  FIFO not full
- vid_data  out  24  {red,green,blue}
- vid_de  out  1  active video
- vid_hsync  out  1  horizontal sync
- vid_vsync  out  1  vertical sync
- underflow  out  1  sticky; set on a FIFO-empty pop in RUN
- overflow  out  1  sticky; set on pair_we while full
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy

## Operation
- FIFO is 49 bits wide ({sof, pair}). Push occurs when pair_we && pair_ready. A pair_we while full is dropped and sets overflow. There is no write-to-read bypass: an entry written in cycle n is poppable from cycle n+1.
- Timing counters: h_cnt counts 0..H_TOTAL-1. v_cnt increments when h_cnt wraps and itself wraps at V_TOTAL-1.
- Active region: h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
- hsync is asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). vsync uses the same rule on v_cnt. Both are driven at level SYNC_POL while asserted.
- State machine, WAIT_SOF:
  - While the FIFO head is non-empty with sof=0, pop and discard it, one entry per cycle.
  - When the head has sof=1 and the counters sit at h_cnt=0, v_cnt=0, move to RUN in that cycle.
  - All pixels output in this state are black (0x000000).
- State machine, RUN:
  - On even active h_cnt, pop the head. Output bits [23:0] and latch bits [47:24].
  - On odd active h_cnt, output the latched half. No pop.
  - Reorder each half from {r,b,g} to {r,g,b} on output.
- Underflow: an even active slot in RUN with the FIFO empty outputs black, sets underflow, and returns to WAIT_SOF.
- A head with sof=1 reached mid-frame in RUN is consumed as normal data. No resync occurs.
- H_ACTIVE must be even.
- Reset:
  - Counters, FIFO and flags clear.
  - State goes to WAIT_SOF.
  - vid_data=0, vid_de=0.
  - vid_hsync and vid_vsync go to the inactive level (~SYNC_POL).
  - pair_ready=1, fifo_level=0.
  - Reset asserted mid-frame discards all buffered pairs.

## Timing
- All vid_* outputs are registered and mutually aligned. The outputs for counter state (h,v) appear one cycle after the counters hold (h,v).
- The pop happens in the same cycle the counters indicate the even slot. fifo_level reflects it on the next edge.
- pair_ready is combinational from the registered level: it is low only when level==FIFO_DEPTH.
- Simultaneous push and pop: level is unchanged. A pop from empty never occurs; the underflow path is taken instead.
- Throughput: 1 pair per 2 active clocks. The upstream must sustain 320 pairs per line.
- Latency from first-SOF push to first vid_de pixel: at least 1 cycle plus the wait for the next frame origin.

## Configuration
- HDMI_OUT_TEST_PATTERN_EN:
  - Defined: any pixel that would be black because of WAIT_SOF or underflow shows eight vertical colour bars of width H_ACTIVE/8. The bar order is white, yellow, cyan, green, magenta, red, blue, black (full-scale 0xFF/0x00 components).
  - Undefined: those pixels are 0x000000.
  - Timing, FIFO and flag behaviour are identical in both builds.

## Test plan
- Reset with small parameters (H_ACTIVE=8, V_ACTIVE=2, porches 2/2/2, V 1/1/1), then hold rst high 3 cycles. Required: vid_de=0, syncs inactive, pair_ready=1, fifo_level=0.
- Push 8 pairs with sof on the first, pair_in=0x112233_445566. Required: from the frame origin, vid_data alternates 0x446655 and 0x113322 for 16 de cycles, and underflow stays 0.
- Push 2 non-SOF pairs, then an SOF pair. Required: the 2 pairs are discarded in WAIT_SOF, and output starts with the SOF pair at the next frame origin.
- Starve the FIFO after 3 pairs in RUN. Required: the 4th even slot outputs 0x000000 (colour bar with the macro defined), underflow=1, and the block waits for the next SOF.
- Write 20 pairs with no pops at FIFO_DEPTH=16. Required: pair_ready drops after the 16th pair, overflow=1, fifo_level=16.
- Assert rst mid-line with FIFO_DEPTH=4 and 3 entries buffered. Required: the next cycle shows fifo_level=0, vid_de=0 and state WAIT_SOF.
